regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file for the RISC-V cores: NRD
//  combinational read ports, two write ports, optional write-to-read bypass.
//  Per-register busy scoreboard (reserve on issue, release on writeback).
//  Sequenced sweep-clear FSM zeroes the file without asserting reset.
//  Sits between decode (reads, reservations) and writeback (two result buses).
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of registers; AW = $clog2(NREGS)
//  NRD       2   number of read ports
//  BYPASS    1   1: a same-cycle write is forwarded to matching reads; 0: no forwarding
//  ZERO_REG  1   1: register 0 is hardwired to zero; its writes and reservations are ignored
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous, active-high reset
//  rd_addr   in   NRD*AW    read addresses; port k = [k*AW +: AW]
//  rd_data   out  NRD*XLEN  read data; port k = [k*XLEN +: XLEN]
//  rd_ready  out  NRD       port k operand valid (register not busy, or bypassed)
//  wr0_en    in   1         write port 0 enable
//  wr0_addr  in   AW        write port 0 address
//  wr0_data  in   XLEN      write port 0 data
//  wr1_en    in   1         write port 1 enable (wins over port 0)
//  wr1_addr  in   AW        write port 1 address
//  wr1_data  in   XLEN      write port 1 data
//  res_en    in   1         reserve (mark busy) register res_addr
//  res_addr  in   AW        register to reserve
//  clr_req   in   1         start sweep-clear (pulse; sampled in IDLE only)
//  clr_busy  out  1         sweep-clear in progress
// BEHAVIOUR
//  Reset (async): all registers 0, all busy bits 0, FSM=IDLE, sweep counter 0,
//   clr_busy=0. rd_data/rd_ready follow combinationally (data 0, ready 1).
//   Reset asserted mid-sweep aborts the sweep immediately.
//  Reads: combinational, zero latency. Address >= NREGS reads 0, ready=1.
//   ZERO_REG=1 and address 0: data 0, ready 1 always.
//  Writes: take effect on the rising edge. Same address on both ports: port 1
//   data is stored. Address 0 (ZERO_REG=1) or >= NREGS: write is dropped.
//  Bypass (BYPASS=1, FSM=IDLE): if rd_addr matches an enabled, non-dropped write
//   address, rd_data = that write data (port 1 over port 0) and rd_ready=1.
//   With BYPASS=0, reads return stored contents; new value is visible next cycle.
//  Scoreboard: a write clears busy[addr] at the edge; res_en sets busy[res_addr].
//   Same edge, same address: reserve wins (busy stays 1; data still written).
//   rd_ready[k] = ~busy[rd_addr[k]], except when bypass applies.
//  Sweep FSM: IDLE --clr_req--> SWEEP. In SWEEP, clr_busy=1; each cycle
//   reg[cnt]<=0, busy[cnt]<=0, cnt++. After cnt=NREGS-1: cnt<=0, -> IDLE.
//   The sweep takes exactly NREGS cycles; clr_busy falls on the edge that clears
//   the last register. In SWEEP, writes and reservations are dropped and bypass
//   is off. Reads return current contents (partially cleared). clr_req during
//   SWEEP is ignored. A clr_req and a write in the same IDLE cycle: the write is
//   performed, then the sweep starts next cycle.
// TESTING
//  1 reset; wr0 x5=0xDEADBEEF; next cycle rd x5 -> 0xDEADBEEF, ready=1.
//  2 wr0 x7=0x11, wr1 x7=0x22 same cycle -> x7=0x22; with BYPASS=1 read of
//    x7 in that cycle -> 0x22.
//  3 wr x0=0xFFFF_FFFF and res x0 -> rd x0 = 0, ready=1 (ZERO_REG=1).
//  4 res x3 -> next cycle rd x3 ready=0; write x3=9 -> ready=1 combinationally
//    (BYPASS=1); same-edge res+write x3 -> busy stays 1, x3=9.
//  5 fill x1..x31 with index; clr_req -> clr_busy high 32 cycles; write x4 during
//    SWEEP is dropped; afterwards all regs read 0 and all ready=1.
//  6 assert rst at sweep cycle 10 -> clr_busy=0 and all regs 0 immediately;
//    new clr_req accepted after reset release.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard,
// optional write-to-read bypass and a sequenced sweep-clear FSM.
module regfile_mp_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                res_en,
  input  logic [AW-1:0]       res_addr,
  input  logic                clr_req,
  output logic                clr_busy
);

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  logic idle_c;
  logic w0_ok_c, w1_ok_c, res_ok_c;

  // Address is backed by real storage (in range and not the hardwired zero).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign idle_c   = (state_q == ST_IDLE);
  assign w0_ok_c  = idle_c && wr0_en && addr_ok(wr0_addr);
  assign w1_ok_c  = idle_c && wr1_en && addr_ok(wr1_addr);
  assign res_ok_c = idle_c && res_en && addr_ok(res_addr);
  assign clr_busy = (state_q == ST_SWEEP);

  // Combinational read ports; port 1 write bypass has priority over port 0.
  always_comb begin
    rd_data  = '0;
    rd_ready = '1;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      if (addr_ok(a)) begin
        rd_data[k*XLEN +: XLEN] = regs_q[a];
        rd_ready[k]             = ~busy_q[a];
        if (BYPASS != 0) begin
          if (w0_ok_c && (a == wr0_addr)) begin
            rd_data[k*XLEN +: XLEN] = wr0_data;
            rd_ready[k]             = 1'b1;
          end
          if (w1_ok_c && (a == wr1_addr)) begin
            rd_data[k*XLEN +: XLEN] = wr1_data;
            rd_ready[k]             = 1'b1;
          end
        end
      end
    end
  end

  // Next-state: writes and reservations in IDLE, one register cleared per SWEEP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w0_ok_c) begin
          regs_d[wr0_addr] = wr0_data;
          busy_d[wr0_addr] = 1'b0;
        end
        if (w1_ok_c) begin
          regs_d[wr1_addr] = wr1_data;
          busy_d[wr1_addr] = 1'b0;
        end
        // Reservation applied last so it wins over a same-edge writeback.
        if (res_ok_c) begin
          busy_d[res_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == AW'(NREGS - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed, table-driven bench for regfile_mp_scoreboard with hand-written
// sweep-clear and reset-abort sequences.
module tb_regfile_mp_scoreboard;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic                wr0_en, wr1_en, res_en, clr_req;
  logic [AW-1:0]       wr0_addr, wr1_addr, res_addr;
  logic [XLEN-1:0]     wr0_data, wr1_data;
  logic                clr_busy;

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .res_en(res_en), .res_addr(res_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  typedef struct {
    logic            w0e;
    logic [AW-1:0]   w0a;
    logic [XLEN-1:0] w0d;
    logic            w1e;
    logic [AW-1:0]   w1a;
    logic [XLEN-1:0] w1d;
    logic            re;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d0;
    logic            r0;
    logic [XLEN-1:0] d1;
    logic            r1;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic vec_t mk(
    input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
    input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
    input logic re, input logic [AW-1:0] ra,
    input logic [AW-1:0] a0, input logic [XLEN-1:0] d0, input logic r0,
    input logic [AW-1:0] a1, input logic [XLEN-1:0] d1, input logic r1);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.re  = re;  v.ra  = ra;
    v.a0  = a0;  v.d0  = d0;  v.r0  = r0;
    v.a1  = a1;  v.d1  = d1;  v.r1  = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    res_en = 1'b0; res_addr = '0; clr_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  // Run an active sweep to completion (bounded) and return its length in cycles.
  task automatic count_sweep(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clr_busy) break;
      cycles++;
      next_cycle();
    end
  endtask

  initial begin
    int cyc;
    // Columns: wr0(en,addr,data) wr1(en,addr,data) res(en,addr) | port0(addr,data,rdy) port1(addr,data,rdy)
    vecs[0]  = mk(0,0,0,          0,0,0,       0,0, 5,0,1,          0,0,1);
    vecs[1]  = mk(1,5,32'hDEADBEEF,0,0,0,      0,0, 5,32'hDEADBEEF,1, 6,0,1);
    vecs[2]  = mk(0,0,0,          0,0,0,       0,0, 5,32'hDEADBEEF,1, 5,32'hDEADBEEF,1);
    vecs[3]  = mk(1,7,32'h11,     1,7,32'h22,  0,0, 7,32'h22,1,     5,32'hDEADBEEF,1);
    vecs[4]  = mk(0,0,0,          0,0,0,       0,0, 7,32'h22,1,     7,32'h22,1);
    vecs[5]  = mk(1,0,32'hFFFFFFFF,0,0,0,      1,0, 0,0,1,          0,0,1);
    vecs[6]  = mk(0,0,0,          0,0,0,       0,0, 0,0,1,          7,32'h22,1);
    vecs[7]  = mk(0,0,0,          0,0,0,       1,3, 3,0,1,          7,32'h22,1);
    vecs[8]  = mk(0,0,0,          0,0,0,       0,0, 3,0,0,          3,0,0);
    vecs[9]  = mk(0,0,0,          1,3,9,       0,0, 3,9,1,          7,32'h22,1);
    vecs[10] = mk(0,0,0,          0,0,0,       0,0, 3,9,1,          3,9,1);
    vecs[11] = mk(1,3,9,          0,0,0,       1,3, 3,9,1,          4,0,1);
    vecs[12] = mk(0,0,0,          0,0,0,       0,0, 3,9,0,          3,9,0);
    vecs[13] = mk(1,9,32'h99,     1,3,5,       0,0, 3,5,1,          9,32'h99,1);
    vecs[14] = mk(0,0,0,          0,0,0,       0,0, 3,5,1,          9,32'h99,1);
    vecs[15] = mk(1,10,32'h10,    0,0,0,       1,9, 9,32'h99,1,     10,32'h10,1);
    vecs[16] = mk(0,0,0,          0,0,0,       0,0, 9,32'h99,0,     10,32'h10,1);

    idle_in();
    rd_addr = {5'd5, 5'd0};
    rst = 1'b1;
    #12;
    chk("reset_clr_busy", 32'(clr_busy), 0);
    chk("reset_rd0", rd_data[31:0], 0);
    chk("reset_rd1", rd_data[63:32], 0);
    chk("reset_ready", 32'(rd_ready), 32'h3);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
      wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
      res_en = vecs[i].re;  res_addr = vecs[i].ra;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      @(negedge clk);
      chk($sformatf("vec%0d_d0", i), rd_data[31:0], vecs[i].d0);
      chk($sformatf("vec%0d_r0", i), 32'(rd_ready[0]), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_d1", i), rd_data[63:32], vecs[i].d1);
      chk($sformatf("vec%0d_r1", i), 32'(rd_ready[1]), 32'(vecs[i].r1));
      next_cycle();
    end

    // Fill x1..x31 with their index.
    for (int r = 1; r < NREGS; r++) begin
      wr0_en = 1'b1; wr0_addr = AW'(r); wr0_data = XLEN'(r);
      next_cycle();
    end
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = {5'd0, AW'(r)};
      #1;
      chk($sformatf("fill_x%0d", r), rd_data[31:0], XLEN'(r));
      chk($sformatf("fill_rdy_x%0d", r), 32'(rd_ready[0]), 1);
    end

    // Sweep request together with a write: write lands, sweep starts next cycle.
    clr_req = 1'b1; wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h77;
    next_cycle();
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clr_busy) break;
      cyc++;
      if (i == 0) rd_addr = {5'd0, 5'd2};
      if (i == 1) begin
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'hBBBB;
        res_en = 1'b1; res_addr = 5'd4;
        rd_addr = {5'd6, 5'd4};
      end
      if (i == 3) rd_addr = {5'd5, 5'd2};
      if (i == 5) clr_req = 1'b1;
      @(negedge clk);
      if (i == 0) chk("sweep_write_landed_x2", rd_data[31:0], 32'h77);
      if (i == 1) begin
        chk("sweep_no_bypass_x4", rd_data[31:0], 4);
        chk("sweep_no_res_rdy_x4", 32'(rd_ready[0]), 1);
        chk("sweep_no_bypass_x6", rd_data[63:32], 6);
      end
      if (i == 3) begin
        chk("sweep_partial_x2", rd_data[31:0], 0);
        chk("sweep_partial_x5", rd_data[63:32], 5);
      end
      next_cycle();
    end
    chk("sweep_len", 32'(cyc), 32'(NREGS));
    chk("sweep_done_busy", 32'(clr_busy), 0);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = {5'd0, AW'(r)};
      #1;
      chk($sformatf("clr_x%0d", r), rd_data[31:0], 0);
      chk($sformatf("clr_rdy_x%0d", r), 32'(rd_ready[0]), 1);
    end

    // Reset during a sweep aborts it and clears the file at once.
    wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'h20;
    wr1_en = 1'b1; wr1_addr = 5'd30; wr1_data = 32'h30;
    rd_addr = {5'd30, 5'd20};
    next_cycle();
    clr_req = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) next_cycle();
    chk("pre_rst_busy", 32'(clr_busy), 1);
    chk("pre_rst_x20", rd_data[31:0], 32'h20);
    chk("pre_rst_x30", rd_data[63:32], 32'h30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", 32'(clr_busy), 0);
    chk("rst_abort_x20", rd_data[31:0], 0);
    chk("rst_abort_x30", rd_data[63:32], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_req = 1'b1;
    next_cycle();
    chk("post_rst_clr_accepted", 32'(clr_busy), 1);
    count_sweep(cyc);
    chk("post_rst_sweep_len", 32'(cyc), 32'(NREGS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
